// File: rtl/dct_stream_sequencer.sv
// Stream sequencer for a bit-serial DCT core: serializes N parallel samples to the core,
// fires the transform, then deserializes N coefficients back with a response timeout.
module dct_stream_sequencer #(
    parameter int DW      = 16,
    parameter int TIMEOUT = 4096
) (
    input  logic          iClk,
    input  logic          iRst_n,
    input  logic          iStart,
    input  logic [2:0]    iSizeCfg,
    input  logic [DW-1:0] iSample,
    input  logic          iSampleVal,
    output logic          oSampleRdy,
    output logic          oCoreSDAT,
    output logic          oCoreSVAL,
    output logic          oCoreValid,
    output logic [2:0]    oCoreSize,
    input  logic          iCoreSDAT,
    input  logic          iCoreSVAL,
    output logic [DW-1:0] oCoef,
    output logic          oCoefVal,
    output logic [4:0]    oCoefIdx,
    output logic          oBusy,
    output logic          oDone,
    output logic          oErr
);

    localparam int BW = $clog2(DW);
    localparam int TW = $clog2(TIMEOUT + 1);
    localparam logic [BW-1:0] LAST_BIT = BW'(DW - 1);
    localparam logic [TW-1:0] TO_LAST  = TW'(TIMEOUT - 1);

    localparam logic [2:0] IDLE = 3'd0;
    localparam logic [2:0] LOAD = 3'd1;
    localparam logic [2:0] FIRE = 3'd2;
    localparam logic [2:0] WAIT = 3'd3;
    localparam logic [2:0] DONE = 3'd4;

    logic [2:0]    stateQ, stateD;
    logic [2:0]    sizeQ, sizeD;
    logic [5:0]    nQ, nD;
    logic [5:0]    sampCntQ, sampCntD;
    logic [DW-1:0] shiftQ, shiftD;
    logic [BW-1:0] bitCntQ, bitCntD;
    logic          shiftActQ, shiftActD;
    logic [DW-1:0] capQ, capD;
    logic [BW-1:0] capBitQ, capBitD;
    logic [5:0]    coefCntQ, coefCntD;
    logic [TW-1:0] toCntQ, toCntD;
    logic [DW-1:0] coefQ, coefD;
    logic          coefValQ, coefValD;
    logic [4:0]    coefIdxQ, coefIdxD;
    logic          doneQ, doneD;
    logic          errQ, errD;

    logic          sampleRdy;
    logic          accept;
    logic          lastBit;
    logic [DW-1:0] capShift;

    // A new sample may be taken while the previous one is still emitting its final bit,
    // which keeps the serial stream gap-free across sample boundaries.
    assign lastBit   = shiftActQ && (bitCntQ == LAST_BIT);
    assign sampleRdy = (stateQ == LOAD) && (sampCntQ != nQ) && (!shiftActQ || lastBit);
    assign accept    = sampleRdy && iSampleVal;
    assign capShift  = (capQ << 1) | DW'(iCoreSDAT);

    always_comb begin
        stateD    = stateQ;
        sizeD     = sizeQ;
        nD        = nQ;
        sampCntD  = sampCntQ;
        shiftD    = shiftQ;
        bitCntD   = bitCntQ;
        shiftActD = shiftActQ;
        capD      = capQ;
        capBitD   = capBitQ;
        coefCntD  = coefCntQ;
        toCntD    = toCntQ;
        coefD     = coefQ;
        coefValD  = 1'b0;
        coefIdxD  = coefIdxQ;
        doneD     = 1'b0;
        errD      = 1'b0;

        if (accept) begin
            shiftD    = iSample;
            bitCntD   = '0;
            shiftActD = 1'b1;
            sampCntD  = sampCntQ + 6'd1;
        end else if (shiftActQ) begin
            if (lastBit) begin
                shiftD    = '0;
                bitCntD   = '0;
                shiftActD = 1'b0;
            end else begin
                shiftD  = shiftQ << 1;
                bitCntD = bitCntQ + BW'(1);
            end
        end

        case (stateQ)
            IDLE: begin
                if (iStart) begin
                    if (iSizeCfg <= 3'd3) begin
                        sizeD    = iSizeCfg;
                        nD       = 6'd4 << iSizeCfg[1:0];
                        sampCntD = '0;
                        stateD   = LOAD;
                    end else begin
                        errD = 1'b1;
                    end
                end
            end
            LOAD: begin
                if (lastBit && (sampCntQ == nQ)) begin
                    stateD = FIRE;
                end
            end
            FIRE: begin
                stateD   = WAIT;
                toCntD   = '0;
                capD     = '0;
                capBitD  = '0;
                coefCntD = '0;
            end
            WAIT: begin
                if (iCoreSVAL) begin
                    capD   = capShift;
                    toCntD = '0;
                    if (capBitQ == LAST_BIT) begin
                        capBitD  = '0;
                        coefD    = capShift;
                        coefValD = 1'b1;
                        coefIdxD = coefCntQ[4:0];
                        coefCntD = coefCntQ + 6'd1;
                        if (coefCntQ == nQ - 6'd1) begin
                            stateD = DONE;
                        end
                    end else begin
                        capBitD = capBitQ + BW'(1);
                    end
                end else if (toCntQ == TO_LAST) begin
                    // Core went silent: drop the partial word and abort without oDone.
                    errD    = 1'b1;
                    stateD  = IDLE;
                    capD    = '0;
                    capBitD = '0;
                    toCntD  = '0;
                end else begin
                    toCntD = toCntQ + TW'(1);
                end
            end
            DONE: begin
                doneD  = 1'b1;
                stateD = IDLE;
            end
            default: begin
                stateD = IDLE;
            end
        endcase
    end

    always_ff @(posedge iClk or negedge iRst_n) begin
        if (!iRst_n) begin
            stateQ    <= IDLE;
            sizeQ     <= '0;
            nQ        <= '0;
            sampCntQ  <= '0;
            shiftQ    <= '0;
            bitCntQ   <= '0;
            shiftActQ <= 1'b0;
            capQ      <= '0;
            capBitQ   <= '0;
            coefCntQ  <= '0;
            toCntQ    <= '0;
            coefQ     <= '0;
            coefValQ  <= 1'b0;
            coefIdxQ  <= '0;
            doneQ     <= 1'b0;
            errQ      <= 1'b0;
        end else begin
            stateQ    <= stateD;
            sizeQ     <= sizeD;
            nQ        <= nD;
            sampCntQ  <= sampCntD;
            shiftQ    <= shiftD;
            bitCntQ   <= bitCntD;
            shiftActQ <= shiftActD;
            capQ      <= capD;
            capBitQ   <= capBitD;
            coefCntQ  <= coefCntD;
            toCntQ    <= toCntD;
            coefQ     <= coefD;
            coefValQ  <= coefValD;
            coefIdxQ  <= coefIdxD;
            doneQ     <= doneD;
            errQ      <= errD;
        end
    end

    assign oSampleRdy = sampleRdy;
    assign oCoreSVAL  = shiftActQ;
    assign oCoreSDAT  = shiftActQ & shiftQ[DW-1];
    assign oCoreValid = (stateQ == FIRE);
    assign oCoreSize  = sizeQ;
    assign oCoef      = coefQ;
    assign oCoefVal   = coefValQ;
    assign oCoefIdx   = coefIdxQ;
    assign oBusy      = (stateQ != IDLE);
    assign oDone      = doneQ;
    assign oErr       = errQ;

endmodule

// File: doc/dct_stream_sequencer.md
DCT_STREAM_SEQUENCER -- requirements
Module: dct_stream_sequencer

Interface
REQ-001 Parameter DW, default 16, sample/coefficient width in bits.
REQ-002 Parameter TIMEOUT, default 4096, maximum cycles in WAIT before abort.
REQ-003 iClk  input  1  single clock; all state updates on rising edge.
REQ-004 iRst_n  input  1  asynchronous active-low reset.
REQ-005 iStart  input  1  request a new transform, one-cycle pulse.
REQ-006 iSizeCfg  input  3  transform size code: 0=4, 1=8, 2=16, 3=32 points; 4-7 illegal.
REQ-007 iSample  input  DW  parallel time-domain sample.
REQ-008 iSampleVal  input  1  iSample valid.
REQ-009 oSampleRdy  output  1  sequencer accepts iSample this cycle.
REQ-010 oCoreSDAT  output  1  serial sample bit to the DCT core.
REQ-011 oCoreSVAL  output  1  oCoreSDAT valid.
REQ-012 oCoreValid  output  1  one-cycle transform-start pulse to the core.
REQ-013 oCoreSize  output  3  size code to the core, held for the whole operation.
REQ-014 iCoreSDAT  input  1  serial coefficient bit from the core.
REQ-015 iCoreSVAL  input  1  iCoreSDAT valid.
REQ-016 oCoef  output  DW  deserialized coefficient.
REQ-017 oCoefVal  output  1  one-cycle pulse, oCoef and oCoefIdx valid.
REQ-018 oCoefIdx  output  5  coefficient index, 0 first.
REQ-019 oBusy  output  1  high in any state other than IDLE.
REQ-020 oDone  output  1  one-cycle pulse after the last coefficient.
REQ-021 oErr  output  1  one-cycle pulse on illegal size or timeout.

Function
REQ-022 States: IDLE, LOAD, FIRE, WAIT, DONE.
REQ-023 IDLE: iStart with legal code -> latch N and code, drive oCoreSize, go to LOAD; illegal code -> oErr pulse next cycle, remain IDLE.
REQ-024 iStart outside IDLE is ignored, with no effect on state or outputs.
REQ-025 LOAD: oSampleRdy high when the shifter is empty or shifting its last bit; sample accepted on iSampleVal&oSampleRdy.
REQ-026 An accepted sample is shifted MSB first, one bit per cycle, starting the cycle after acceptance, with oCoreSVAL high for exactly DW cycles.
REQ-027 Back-to-back accepted samples produce contiguous oCoreSVAL with no gap cycle.
REQ-028 oSampleRdy is low once N samples are accepted.
REQ-029 After the last bit of sample N-1 -> FIRE: oCoreValid high one cycle, then WAIT.
REQ-030 WAIT: each cycle with iCoreSVAL high shifts iCoreSDAT in MSB first; cycles with iCoreSVAL low are ignored and may occur mid-word.
REQ-031 On the DW-th captured bit, the registered word is presented on oCoef with oCoefVal pulsed the following cycle and oCoefIdx = count (0..N-1).
REQ-032 After coefficient N-1 -> DONE: oDone pulse one cycle, then IDLE.
REQ-033 Timeout counter clears on entering WAIT and on every captured bit; on reaching TIMEOUT -> oErr pulse, partial word discarded, return to IDLE with no oDone.
REQ-034 iCoreSVAL outside WAIT is ignored.
REQ-035 Sample counter width 6 bits, bit counter width clog2(DW); no wrap beyond N or DW.
REQ-036 oCoef holds its last value between pulses; oCoreSDAT is 0 when oCoreSVAL is low.

Reset
REQ-037 While iRst_n is low, all outputs are 0, state is IDLE, and all counters/shifters are 0, including mid-operation.
REQ-038 After iRst_n rises, the first iStart is honoured on the first clock edge.

Verification
REQ-039 Size 0, four samples 0x0001,0x8000,0x00FF,0xFFFF back-to-back -> 64 contiguous oCoreSVAL cycles with exact MSB-first bits, then oCoreValid 1 cycle, oCoreSize=0.
REQ-040 Core model returns 8 words 0x1234.. with random iCoreSVAL gaps -> 8 oCoefVal pulses, oCoefIdx 0..7, values exact, then oDone 1 cycle, oBusy low.
REQ-041 iSizeCfg=5 with iStart -> oErr 1 cycle, oBusy stays 0, no oCoreSVAL.
REQ-042 Size 3, no core response -> oErr exactly TIMEOUT cycles after entering WAIT, no oDone, state IDLE.
REQ-043 iRst_n low mid-LOAD (sample 10 of 32) -> all outputs 0 immediately; a new size-1 run then completes correctly.
REQ-044 iStart pulsed during LOAD and WAIT -> no effect; size latched at start is unchanged.
